if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction-fetch front end for the 5-stage LEGv8 pipeline. Owns the fetch PC and issues word requests to instruction memory. Buffers returned instructions, each tagged with its PC, in a small in-order queue that feeds the IF/ID pipeline register. Handles the branch redirect signalled from EX/MEM and squashes wrong-path fetches, so IF/ID sees only correct-path instructions.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 64'h0, fetch PC after reset
- MAX_OUTSTANDING, 2, maximum in-flight imem requests
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  request valid
- imem_addr  out  64  word address of request
- imem_gnt  in  1  request accepted this cycle; only meaningful with imem_req
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  32  instruction word
- redirect  in  1  taken branch (pcSrc)
- redirect_pc  in  64  branch target; bits [1:0] are ignored and treated as 0
- out_valid  out  1  queue head valid toward IF/ID
- out_ready  in  1  IF/ID accepts; low means stall
- out_pc  out  64  PC of head instruction
- out_inst  out  32  head instruction

## Operation
- **Request issue.** imem_req = !reset && (q_count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - This credit rule guarantees every response has a queue slot. A response is never dropped for lack of space.
- **Request accept.** A request is accepted on imem_req && imem_gnt. On accept: fetch_pc += 4 (modulo 2^64, wraps silently), outstanding++.
- **Response return.** On imem_rvalid:
  - If discard_cnt > 0: decrement discard_cnt and drop the word.
  - Otherwise: push {resp_pc, imem_rdata} into the queue, then resp_pc += 4.
  - In both cases, outstanding--.
- **Dequeue.** The queue pops on out_valid && out_ready.
  - out_pc/out_inst come from the head entry and are stable while out_valid && !out_ready.
- **Redirect (highest priority).** In the redirect cycle:
  - Flush the queue, so q_count = 0 next cycle.
  - fetch_pc and resp_pc ← {redirect_pc[63:2], 2'b00}.
  - discard_cnt ← outstanding after this cycle's updates, i.e. outstanding + accept − rvalid.
  - A response arriving in the redirect cycle is dropped.
  - A request accepted in the redirect cycle is counted for discard, because its address is wrong-path.
  - A pop in the redirect cycle still completes if out_ready was high.
- **State machine:**
  - RUN: normal operation.
  - SQUASH: entered on redirect when the computed discard_cnt > 0. Left for RUN when discard_cnt reaches 0.
  - In SQUASH, new correct-path requests may issue. Their responses follow the discarded ones in order.
  - A redirect in SQUASH recomputes discard_cnt with the same rule.
- **Counter widths.** outstanding and discard_cnt use clog2(MAX_OUTSTANDING+1) bits. q_count uses clog2(DEPTH+1) bits.
- **Simultaneous push and pop on a full queue.** Legal only if the credit rule allowed the push, and it always does. Count is unchanged.
- **Empty-queue bypass.** None: a response reaches out_valid one cycle after imem_rvalid.

## Timing
- **Reset values:**
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0.
  - fetch_pc=resp_pc=RESET_PC; q_count=outstanding=discard_cnt=0; state RUN.
  - Reset mid-operation abandons all in-flight requests. Responses that arrive after reset are not discarded. The memory is reset together with this block.
- **Latency.** First imem_req is the cycle after reset deasserts. Response-to-out_valid latency is 1 cycle.
- **Throughput.** With single-cycle memory and out_ready held high, one instruction per cycle.
- **Redirect.** Target request issues the cycle after redirect. Wrong-path entries are never presented once redirect is sampled: out_valid is 0 in the following cycle.
- **imem_addr stability.** imem_addr equals fetch_pc and holds while imem_req && !imem_gnt.

## Structure
- **Shared package `cpu_pkg`:**
  - INST_W=32, ADDR_W=64, PC_STEP=64'd4.
  - Fetch state enum {RUN, SQUASH}.
  - Queue entry struct {pc[63:0], inst[31:0]}.
- **Sub-module `sync_fifo`** (parameters WIDTH, DEPTH). It provides:
  - push, pop, flush;
  - count, empty, full;
  - head data via registered read pointer.
- if_fetch_queue holds the PC registers, credit counters and the squash FSM.

## Test plan
1. Reset, then memory with 1-cycle response and out_ready=1 → out_pc sequence 0,4,8,12 on consecutive cycles; out_inst matches the memory image.
2. out_ready=0 for 10 cycles → exactly DEPTH=4 entries buffered. imem_req drops once q_count+outstanding=4. Head holds PC 0 stable. Release → PCs 0..12 then 16 with no gap or duplicate.
3. Two requests in flight (PCs 8,12), then redirect with redirect_pc=64'h103 → both responses dropped. The next out_pc is 64'h100 and the next request address is 64'h100.
4. Redirect in the same cycle as imem_rvalid and imem_gnt → the response is dropped, the accepted request is counted, and discard_cnt equals the count in flight. No wrong-path out_valid afterward.
5. RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 → out_pc sequence FFF8, FFFC, 0, 4, with correct wrap.
6. Assert reset while 2 requests are outstanding and the queue holds 3 entries → the next cycle has out_valid=0 and imem_req=0. The following cycle has imem_req=1 with imem_addr=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline front end.
// Entry layout and fetch state are used by the fetch queue and its FIFO.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] a
    );
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is read through a registered
// read pointer so the head word stays put until it is popped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdata = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// LEGv8 fetch front end: PC generation, credit-limited imem requests,
// in-order instruction queue and wrong-path squash on branch redirect.
module if_fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter logic [63:0] RESET_PC        = 64'h0,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = ((OW > CW) ? OW : CW) + 1;

    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     outstanding_nxt;
    logic [OW-1:0]     discard_cnt;
    logic [CW-1:0]     q_count;
    logic [SW-1:0]     credit_used;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] target;
    fetch_state_e      state;
    fetch_entry_t      q_wdata;
    fetch_entry_t      q_head;
    logic              accept;
    logic              squashing;
    logic              drop;
    logic              q_push;
    logic              q_pop;
    logic              q_empty;
    logic              q_full;

    // Slots are reserved at request time, so a response always fits.
    assign credit_used = SW'(q_count) + SW'(outstanding);
    assign imem_req    = !reset
                       && (credit_used < SW'(DEPTH))
                       && (outstanding < OW'(MAX_OUTSTANDING));
    assign imem_addr   = fetch_pc;
    assign accept      = imem_req && imem_gnt;

    assign squashing = (state == SQUASH) && (discard_cnt != '0);
    assign drop      = redirect || squashing;
    assign q_pop     = out_valid && out_ready;
    assign q_push    = imem_rvalid && !drop && (!q_full || q_pop);
    assign q_wdata   = '{pc: resp_pc, inst: imem_rdata};

    assign outstanding_nxt = outstanding + OW'(accept) - OW'(imem_rvalid);
    assign target          = word_align(redirect_pc);

    assign out_valid = !q_empty;
    assign out_pc    = q_empty ? '0 : q_head.pc;
    assign out_inst  = q_empty ? '0 : q_head.inst;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect),
        .wdata (q_wdata),
        .rdata (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            state       <= RUN;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                // Everything still in flight after this edge is wrong-path.
                fetch_pc    <= target;
                resp_pc     <= target;
                discard_cnt <= outstanding_nxt;
                state       <= (outstanding_nxt != '0) ? SQUASH : RUN;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (imem_rvalid) begin
                    if (squashing) begin
                        discard_cnt <= discard_cnt - 1'b1;
                    end else begin
                        resp_pc <= resp_pc + PC_STEP;
                    end
                end
                unique case (state)
                    RUN: state <= RUN;
                    SQUASH: begin
                        if (!squashing
                            || (imem_rvalid && discard_cnt == OW'(1))) begin
                            state <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: random in-order memory,
// stall and redirect stimulus, scoreboard of the correct-path PC stream.
module tb_if_fetch_queue;

    localparam logic [63:0] RST_PC  = 64'h0;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam int          MAX_OUT = 2;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    logic        w_req;
    logic [63:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [63:0] w_pc;
    logic [31:0] w_inst;
    logic        w_acc = 1'b0;
    logic [63:0] w_acc_addr = '0;
    int          w_chk = 0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gnt_pct = 100;
    int          max_lat = 1;
    int          mem_lat;
    int          pop_cnt = 0;
    req_t        pend[$];
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic [63:0] next_pc = RST_PC;
    bit          restart = 1'b0;
    logic [63:0] restart_pc = RST_PC;

    bit          prev_stall = 1'b0;
    bit          prev_wait = 1'b0;
    bit          after_redir = 1'b0;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;
    logic [63:0] prev_addr;
    logic [63:0] redir_tgt;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH           (4),
        .RESET_PC        (RST_PC),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst)
    );

    if_fetch_queue #(
        .DEPTH           (4),
        .RESET_PC        (WRAP_PC),
        .MAX_OUTSTANDING (MAX_OUT)
    ) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_gnt    (1'b1),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .redirect    (1'b0),
        .redirect_pc (64'h0),
        .out_valid   (w_valid),
        .out_ready   (1'b1),
        .out_pc      (w_pc),
        .out_inst    (w_inst)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // In-order memory with random grant and latency.
    always begin
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
        #4;
        if (reset) begin
            pend.delete();
        end else if (imem_req && imem_gnt) begin
            mem_lat = $urandom_range(max_lat, 1);
            pend.push_back('{imem_addr, cyc + mem_lat});
            chk("max_outstanding", 64'(pend.size() > MAX_OUT), 64'd0);
        end
        cyc++;
    end

    // Single-cycle memory for the wrap instance.
    always begin
        @(negedge clk);
        w_rvalid = w_acc;
        w_rdata  = mem_word(w_acc_addr);
        #4;
        w_acc      = w_req && !reset;
        w_acc_addr = w_addr;
    end

    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            w_chk = 0;
        end else if (w_valid && w_chk < 4) begin
            chk("wrap_pc", w_pc, WRAP_PC + 64'(4 * w_chk));
            chk("wrap_inst", 64'(w_inst),
                64'(mem_word(WRAP_PC + 64'(4 * w_chk))));
            w_chk++;
        end
    end

    // Monitor: pops against the scoreboard plus protocol properties.
    always begin
        @(negedge clk);
        #4;
        if (reset) begin
            prev_stall  = 1'b0;
            prev_wait   = 1'b0;
            after_redir = 1'b0;
        end else begin
            if (after_redir) begin
                chk("no_wrong_path", 64'(out_valid), 64'd0);
                chk("redirect_addr", imem_addr, redir_tgt);
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_pc", out_pc, prev_pc);
                chk("stall_inst", 64'(out_inst), 64'(prev_inst));
            end
            if (prev_wait) begin
                chk("addr_hold", imem_addr, prev_addr);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual %h required none",
                             out_pc);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("out_pc", out_pc, exp_e);
                    chk("out_inst", 64'(out_inst), 64'(mem_word(exp_e)));
                end
                pop_cnt++;
            end
            prev_stall  = out_valid && !out_ready && !redirect;
            prev_pc     = out_pc;
            prev_inst   = out_inst;
            prev_wait   = imem_req && !imem_gnt && !redirect;
            prev_addr   = imem_addr;
            after_redir = redirect;
            redir_tgt   = {redirect_pc[63:2], 2'b00};
        end
    end

    // Stimulus side keeps the expected correct-path stream topped up.
    task automatic tick();
        @(negedge clk);
        if (restart) begin
            exp_q.delete();
            next_pc = restart_pc;
            restart = 1'b0;
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 64'd4;
        end
        redirect = 1'b0;
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        restart     = 1'b1;
        restart_pc  = {pc[63:2], 2'b00};
    endtask

    task automatic do_reset();
        tick();
        reset      = 1'b1;
        restart    = 1'b1;
        restart_pc = RST_PC;
        tick();
        #4;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_inst", 64'(out_inst), 64'd0);
        tick();
        reset = 1'b0;
        #4;
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", imem_addr, RST_PC);
    endtask

    task automatic expect_head(input string name, input logic [63:0] pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            #4;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, 64'(seen), 64'd1);
        if (seen) chk(name, out_pc, pc);
    endtask

    initial begin
        int c0;
        int r;
        bit found;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Streaming with single-cycle memory.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            #4;
            chk("t1_stream", 64'(out_valid), (i == 1) ? 64'd0 : 64'd1);
        end
        repeat (10) tick();

        // Stall fills the queue to DEPTH and stops requesting.
        out_ready = 1'b0;
        do_reset();
        repeat (11) tick();
        gnt_pct = 0;
        tick();
        #4;
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_head", out_pc, RST_PC);
        chk("t2_req", 64'(imem_req), 64'd0);
        tick();
        out_ready = 1'b1;
        c0 = pop_cnt;
        repeat (8) tick();
        chk("t2_buffered", 64'(pop_cnt - c0), 64'd4);
        gnt_pct = 100;
        repeat (10) tick();
        chk("t2_resume", 64'(pop_cnt - c0 > 4), 64'd1);

        // Redirect with requests in flight; low target bits ignored.
        max_lat = 4;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i > 4 && pend.size() == 2) break;
        end
        do_redirect(64'h103);
        expect_head("t3_head", 64'h100);

        // Redirect coinciding with a response and a grant.
        gnt_pct = 60;
        max_lat = 2;
        found   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            #1;
            if (imem_rvalid && imem_gnt && imem_req) begin
                do_redirect(64'h2000);
                found = 1'b1;
                break;
            end
        end
        chk("t4_found", 64'(found), 64'd1);
        expect_head("t4_head", 64'h2000);

        // Reset while requests are outstanding and entries are queued.
        out_ready = 1'b0;
        gnt_pct   = 100;
        max_lat   = 3;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pend.size() == 2 && out_valid) break;
        end
        do_reset();
        out_ready = 1'b1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i % 250 == 0) begin
                gnt_pct = $urandom_range(100, 20);
                max_lat = $urandom_range(4, 1);
            end
            out_ready = ($urandom_range(99) < 75);
            r = $urandom_range(999);
            if (r < 4) begin
                do_reset();
            end else if (r < 50) begin
                do_redirect({$urandom, $urandom});
            end
        end

        // Full-rate drain.
        out_ready = 1'b1;
        gnt_pct   = 100;
        max_lat   = 1;
        tick();
        c0 = pop_cnt;
        repeat (30) tick();
        chk("drain_rate", 64'(pop_cnt - c0 >= 20), 64'd1);
        chk("wrap_seen", 64'(w_chk), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
